// File: rtl/board_writer.sv
// rtl/board_writer.sv - 2x5 game board register with pair-match clear/score; refill via BOARD_REFILL_EN
module board_writer #(
    parameter int unsigned TARGET     = 0,
    parameter logic [39:0] INIT_BOARD = 40'h1234567893,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         num,
    input  logic               load_en,
    input  logic [39:0]        load_data,
    input  logic               pick_valid,
    output logic               pick_ready,
    input  logic [3:0]         pick_idx0,
    input  logic [3:0]         pick_idx1,
    output logic [39:0]        status,
    output logic               result_valid,
    output logic [1:0]         result_code,
    output logic [3:0]         sum_mod,
    output logic [SCORE_W-1:0] score,
    output logic               board_clear
);

    typedef enum logic [2:0] {IDLE, CHECK, CLEAR, REFILL_A, REFILL_B, DONE} state_t;

    localparam logic [1:0] CODE_MATCH    = 2'b01;
    localparam logic [1:0] CODE_MISMATCH = 2'b10;
    localparam logic [1:0] CODE_INVALID  = 2'b11;

    // Elaboration-time sanity check of the configuration.
    if (TARGET > 9 || LFSR_SEED == 16'h0) begin : g_param_check
        $error("board_writer: TARGET must be 0..9 and LFSR_SEED nonzero");
    end

    state_t             state_q, state_d;
    logic [39:0]        status_q, status_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         idx0_q, idx0_d;
    logic [3:0]         idx1_q, idx1_d;
    logic               result_valid_q, result_valid_d;
    logic [1:0]         result_code_q, result_code_d;
    logic [3:0]         sum_mod_q, sum_mod_d;

    logic [2:0]         num_eff;
    logic [3:0]         slot_v [16];
    logic [3:0]         v0, v1;
    logic               pair_invalid;
    logic [4:0]         pair_sum;
    logic [3:0]         pair_mod;
    logic               is_match;

    // Column of a slot index; rows are 5 slots wide.
    function automatic logic [2:0] col_of(input logic [3:0] idx);
        return (idx >= 4'd5) ? 3'(idx - 4'd5) : idx[2:0];
    endfunction

    // Clamp the active column count into 1..5.
    always_comb begin
        if (num == 3'd0)      num_eff = 3'd1;
        else if (num > 3'd5)  num_eff = 3'd5;
        else                  num_eff = num;
    end

    // Board as an indexable array; out-of-range indices read as an empty slot.
    always_comb begin
        for (int k = 0; k < 10; k++) slot_v[k] = status_q[4*k +: 4];
        for (int k = 10; k < 16; k++) slot_v[k] = 4'h0;
    end

    // Board is clear when every slot in an active column holds 0.
    always_comb begin
        board_clear = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (col_of(4'(k)) < num_eff && slot_v[k] != 4'h0) board_clear = 1'b0;
        end
    end

    // Pair evaluation on the latched indices.
    always_comb begin
        v0           = slot_v[idx0_q];
        v1           = slot_v[idx1_q];
        pair_invalid = (idx0_q == idx1_q) || (idx0_q > 4'd9) || (idx1_q > 4'd9) ||
                       (col_of(idx0_q) >= num_eff) || (col_of(idx1_q) >= num_eff) ||
                       (v0 == 4'h0) || (v1 == 4'h0);
        pair_sum     = {1'b0, v0} + {1'b0, v1};
        pair_mod     = (pair_sum >= 5'd10) ? 4'(pair_sum - 5'd10) : pair_sum[3:0];
        is_match     = (pair_mod == 4'(TARGET));
    end

`ifdef BOARD_REFILL_EN
    logic [15:0] lfsr_q;
    logic [3:0]  refill_val;

    // Map the low LFSR nibble 0..15 onto 1..9 ((x mod 9) + 1).
    always_comb begin
        refill_val = (lfsr_q[3:0] >= 4'd9) ? (lfsr_q[3:0] - 4'd8) : (lfsr_q[3:0] + 4'd1);
    end

    // Free-running Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
`endif

    // FSM next-state and datapath updates.
    always_comb begin
        state_d        = state_q;
        status_d       = status_q;
        score_d        = score_q;
        idx0_d         = idx0_q;
        idx1_d         = idx1_q;
        result_valid_d = 1'b0;
        result_code_d  = result_code_q;
        sum_mod_d      = sum_mod_q;
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    status_d = load_data;
                end else if (pick_valid) begin
                    idx0_d  = pick_idx0;
                    idx1_d  = pick_idx1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (pair_invalid) begin
                    result_valid_d = 1'b1;
                    result_code_d  = CODE_INVALID;
                    sum_mod_d      = 4'h0;
                    state_d        = IDLE;
                end else begin
                    sum_mod_d = pair_mod;
                    if (is_match) begin
                        state_d = CLEAR;
                    end else begin
                        result_valid_d = 1'b1;
                        result_code_d  = CODE_MISMATCH;
                        state_d        = IDLE;
                    end
                end
            end
            CLEAR: begin
                for (int k = 0; k < 10; k++) begin
                    if (4'(k) == idx0_q || 4'(k) == idx1_q) status_d[4*k +: 4] = 4'h0;
                end
                if (score_q != '1) score_d = score_q + 1'b1;
`ifdef BOARD_REFILL_EN
                state_d = REFILL_A;
`else
                state_d = DONE;
`endif
            end
`ifdef BOARD_REFILL_EN
            REFILL_A: begin
                for (int k = 0; k < 10; k++) begin
                    if (4'(k) == idx0_q) status_d[4*k +: 4] = refill_val;
                end
                state_d = REFILL_B;
            end
            REFILL_B: begin
                for (int k = 0; k < 10; k++) begin
                    if (4'(k) == idx1_q) status_d[4*k +: 4] = refill_val;
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                result_valid_d = 1'b1;
                result_code_d  = CODE_MATCH;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            status_q       <= INIT_BOARD;
            score_q        <= '0;
            idx0_q         <= 4'h0;
            idx1_q         <= 4'h0;
            result_valid_q <= 1'b0;
            result_code_q  <= 2'b00;
            sum_mod_q      <= 4'h0;
        end else begin
            state_q        <= state_d;
            status_q       <= status_d;
            score_q        <= score_d;
            idx0_q         <= idx0_d;
            idx1_q         <= idx1_d;
            result_valid_q <= result_valid_d;
            result_code_q  <= result_code_d;
            sum_mod_q      <= sum_mod_d;
        end
    end

    assign pick_ready   = (state_q == IDLE);
    assign status       = status_q;
    assign result_valid = result_valid_q;
    assign result_code  = result_code_q;
    assign sum_mod      = sum_mod_q;
    assign score        = score_q;

endmodule

// File: tb/tb_board_writer.sv
// tb/tb_board_writer.sv - scoreboard bench for board_writer (honours BOARD_REFILL_EN)
module tb_board_writer;

    localparam int          TARGET     = 0;
    localparam logic [39:0] INIT_BOARD = 40'h1234567893;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam int          SCORE_W    = 8;
    localparam int          SCORE_MAX  = (1 << SCORE_W) - 1;
`ifdef BOARD_REFILL_EN
    localparam int          MATCH_LAT  = 5;
`else
    localparam int          MATCH_LAT  = 3;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         num;
    logic               load_en;
    logic [39:0]        load_data;
    logic               pick_valid;
    logic               pick_ready;
    logic [3:0]         pick_idx0;
    logic [3:0]         pick_idx1;
    logic [39:0]        status;
    logic               result_valid;
    logic [1:0]         result_code;
    logic [3:0]         sum_mod;
    logic [SCORE_W-1:0] score;
    logic               board_clear;

    always #5 clk = ~clk;

    board_writer #(
        .TARGET(TARGET), .INIT_BOARD(INIT_BOARD), .LFSR_SEED(LFSR_SEED), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .rst(rst), .num(num), .load_en(load_en), .load_data(load_data),
        .pick_valid(pick_valid), .pick_ready(pick_ready), .pick_idx0(pick_idx0),
        .pick_idx1(pick_idx1), .status(status), .result_valid(result_valid),
        .result_code(result_code), .sum_mod(sum_mod), .score(score), .board_clear(board_clear)
    );

    typedef struct {
        logic [1:0]  code;
        logic [3:0]  sm;
        logic [39:0] board;
        int          score;
        int          c0;
        int          lat;
        int          i0;
        int          i1;
        int          nm;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [39:0] mb;
    int          ms;
    logic [39:0] last_exp_board;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int eff_num(input int n);
        return (n == 0) ? 1 : ((n > 5) ? 5 : n);
    endfunction

    function automatic int slot_of(input logic [39:0] b, input int k);
        return int'(b[4*k +: 4]);
    endfunction

    function automatic bit all_clear(input logic [39:0] b, input int n);
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) < eff_num(n) && slot_of(b, k) != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [39:0] rand_board();
        logic [39:0] b;
        for (int k = 0; k < 10; k++) b[4*k +: 4] = 4'($urandom_range(0, 9));
        return b;
    endfunction

`ifdef BOARD_REFILL_EN
    logic [15:0] lm;
    logic [15:0] hist [256];

    function automatic logic [15:0] lstep(input logic [15:0] x);
        int bitv;
        bitv = (int'(x) ^ (int'(x) >> 2) ^ (int'(x) >> 3) ^ (int'(x) >> 5)) & 1;
        return 16'((int'(x) >> 1) | (bitv << 15));
    endfunction

    function automatic logic [3:0] refill_of(input logic [15:0] x);
        return 4'((int'(x) % 16) % 9 + 1);
    endfunction
`endif

    // Edge counter plus golden LFSR history (value in use at each edge).
    always @(posedge clk) begin
        cyc = cyc + 1;
`ifdef BOARD_REFILL_EN
        if (rst) begin
            lm = LFSR_SEED;
        end else begin
            hist[cyc % 256] = lm;
            lm = lstep(lm);
        end
`endif
    end

    // Monitor: every result pulse pops and compares one expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   ok;
        if (result_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
`ifdef BOARD_REFILL_EN
                if (e.code == 2'b01) begin
                    e.board[4*e.i0 +: 4] = refill_of(hist[(e.c0 + 3) % 256]);
                    e.board[4*e.i1 +: 4] = refill_of(hist[(e.c0 + 4) % 256]);
                    ok = (status[4*e.i0 +: 4] >= 4'd1) && (status[4*e.i0 +: 4] <= 4'd9) &&
                         (status[4*e.i1 +: 4] >= 4'd1) && (status[4*e.i1 +: 4] <= 4'd9);
                    chk("refill_range", 64'(ok), 64'd1);
                end
`endif
                last_exp_board = e.board;
                chk("result_code", 64'(result_code), 64'(e.code));
                chk("sum_mod", 64'(sum_mod), 64'(e.sm));
                chk("status", 64'(status), 64'(e.board));
                chk("score", 64'(score), 64'(e.score));
                chk("latency", 64'(cyc - e.c0), 64'(e.lat));
                chk("board_clear", 64'(board_clear), 64'(all_clear(e.board, e.nm)));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (pick_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (pick_ready !== 1'b1) chk("ready_timeout", 64'(pick_ready), 64'd1);
    endtask

    task automatic wait_results();
        int n = 0;
        while (sbq.size() != 0 && n < 30) begin @(negedge clk); n++; end
        if (sbq.size() != 0) begin
            chk("result_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
`ifdef BOARD_REFILL_EN
        mb = last_exp_board;
`endif
    endtask

    task automatic do_load(input logic [39:0] d);
        wait_ready();
        load_en = 1'b1;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        mb = d;
        chk("load_status", 64'(status), 64'(d));
    endtask

    // Issue one pick; expectation is pushed when the accepting edge is known.
    task automatic do_pick(input int i0, input int i1, input bit push, input bit hold);
        exp_t e;
        int   en, v0, v1, m;
        pick_idx0  = 4'(i0);
        pick_idx1  = 4'(i1);
        pick_valid = 1'b1;
        wait_ready();
        e.c0 = cyc + 1;
        e.i0 = i0;
        e.i1 = i1;
        e.nm = int'(num);
        en = eff_num(e.nm);
        v0 = (i0 <= 9) ? slot_of(mb, i0) : 0;
        v1 = (i1 <= 9) ? slot_of(mb, i1) : 0;
        if (i0 == i1 || i0 > 9 || i1 > 9 || (i0 % 5) >= en || (i1 % 5) >= en || v0 == 0 || v1 == 0) begin
            e.code = 2'b11; e.sm = 4'd0; e.lat = 1;
        end else begin
            m = (v0 + v1) % 10;
            e.sm = 4'(m);
            if (m == TARGET) begin
                e.code = 2'b01; e.lat = MATCH_LAT;
                if (push) begin
                    mb[4*i0 +: 4] = 4'd0;
                    mb[4*i1 +: 4] = 4'd0;
                    ms = (ms < SCORE_MAX) ? ms + 1 : SCORE_MAX;
                end
            end else begin
                e.code = 2'b10; e.lat = 1;
            end
        end
        e.board = mb;
        e.score = ms;
        if (push) sbq.push_back(e);
        @(negedge clk);
        chk("ready_busy", 64'(pick_ready), 64'd0);
        if (!hold) pick_valid = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int i0, i1;
        rst = 1'b1; num = 3'd5; load_en = 1'b0; load_data = '0;
        pick_valid = 1'b0; pick_idx0 = '0; pick_idx1 = '0;
        mb = INIT_BOARD; ms = 0; last_exp_board = INIT_BOARD;
        repeat (2) @(negedge clk);
        chk("rst_status", 64'(status), 64'(INIT_BOARD));
        chk("rst_score", 64'(score), 64'd0);
        chk("rst_ready", 64'(pick_ready), 64'd1);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_board_clear", 64'(board_clear), 64'd0);
        chk("rst_code", 64'(result_code), 64'd0);
        chk("rst_sum_mod", 64'(sum_mod), 64'd0);
        rst = 1'b0;

        // Match (0,5): 3+7 = 10 -> 0.
        do_load(40'h1986754213);
        do_pick(0, 5, 1, 0); wait_results();

        // Mismatch (1,2): 3+4 = 7; load ignored while busy.
        do_load(40'h1986754430);
        do_pick(1, 2, 1, 0);
        load_en = 1'b1; load_data = 40'hFFFFFFFFFF;
        @(negedge clk);
        load_en = 1'b0;
        wait_results();

        // Invalid: same slot, inactive column, cleared slot, index out of range.
        do_pick(2, 2, 1, 0); wait_results();
        num = 3'd2;
        do_pick(1, 4, 1, 0); wait_results();
        num = 3'd5;
        do_pick(0, 1, 1, 0); wait_results();
        do_pick(10, 1, 1, 0); wait_results();

        // Single active column: matching the only pair empties the board.
        num = 3'd1;
        do_load(40'h1986754213);
        do_pick(0, 5, 1, 0); wait_results();
        num = 3'd5;

        // load_en wins over pick_valid in the same IDLE cycle.
        wait_ready();
        load_en = 1'b1; load_data = 40'h1986754430;
        pick_valid = 1'b1; pick_idx0 = 4'd1; pick_idx1 = 4'd2;
        @(negedge clk);
        load_en = 1'b0; pick_valid = 1'b0;
        mb = 40'h1986754430;
        chk("load_priority_status", 64'(status), 64'(mb));
        chk("load_priority_ready", 64'(pick_ready), 64'd1);

        // pick_valid held while busy; index change after acceptance ignored.
        do_pick(1, 2, 1, 1);
        do_pick(3, 6, 1, 0);
        wait_results();

        // Randomized traffic.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_load(rand_board());
            end else begin
                num = 3'($urandom_range(0, 7));
                i0 = $urandom_range(0, 10);
                i1 = $urandom_range(0, 10);
                if ($urandom_range(0, 1) == 1 && i0 <= 9) begin
                    for (int j = 0; j < 10; j++) begin
                        if (j != i0 && (slot_of(mb, i0) + slot_of(mb, j)) % 10 == TARGET) begin
                            i1 = j;
                            break;
                        end
                    end
                end
                do_pick(i0, i1, 1, 0);
                wait_results();
            end
        end

        // Score saturation.
        num = 3'd5;
        for (int it = 0; it < SCORE_MAX + 5; it++) begin
            do_load(40'h1986754213);
            do_pick(0, 5, 1, 0);
            wait_results();
        end

        // Reset while in CLEAR: no result, reset values restored.
        do_load(40'h1986754213);
        do_pick(0, 5, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mb = INIT_BOARD; ms = 0;
        chk("midrst_status", 64'(status), 64'(INIT_BOARD));
        chk("midrst_score", 64'(score), 64'd0);
        chk("midrst_ready", 64'(pick_ready), 64'd1);
        chk("midrst_code", 64'(result_code), 64'd0);
        chk("midrst_sum_mod", 64'(sum_mod), 64'd0);
        repeat (6) begin
            chk("midrst_no_pulse", 64'(result_valid), 64'd0);
            @(negedge clk);
        end
        chk("midrst_status_hold", 64'(status), 64'(INIT_BOARD));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
